// File: rtl/set_pkg.sv
`default_nettype none
// ============================================================================
// Module   : set_pkg
// Brief    : Shared state encoding and command-word sizing for the SET
//            job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package set_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT
  } state_t;

  // central(24) + radius(12) + mode(2); the caller tag is appended per instance
  localparam int CMD_FIXED_W = 24 + 12 + 2;

  localparam logic [7:0] TIMEOUT_CAND = 8'hFF;

  function automatic int cmd_w(input int tag_w);
    return CMD_FIXED_W + tag_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/set_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : set_cmd_fifo
// Brief    : Command queue; pointers carry a wrap bit so count = wptr - rptr.
// Revision : 1.0 - initial release
// ============================================================================
module set_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wptr;
  logic [c_aw:0]    r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  assign o_full    = (o_count == (c_aw+1)'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (c_aw+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (c_aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/set_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : set_job_scheduler
// Brief    : Queues set-query commands, issues them one at a time to SET,
//            and returns {candidate, tag, err} through a single result slot.
// Revision : 1.0 - initial release
// ============================================================================
module set_job_scheduler
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [23:0]      cmd_central,
  input  logic [11:0]      cmd_radius,
  input  logic [1:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [15:0]      jobs_done
);

  localparam int CMD_W = cmd_w(TAG_W);
  localparam int c_wd_w = $clog2(TIMEOUT);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_wd_w-1:0]      r_wd;
  logic                   r_ready_en;
  logic                   r_set_en;
  logic [23:0]            r_set_central;
  logic [11:0]            r_set_radius;
  logic [1:0]             r_set_mode;
  logic [TAG_W-1:0]       r_job_tag;
  logic                   r_res_valid;
  logic [7:0]             r_res_candidate;
  logic [TAG_W-1:0]       r_res_tag;
  logic                   r_res_err;
  logic [15:0]            r_jobs_done;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_done_ok;
  logic                   w_done_to;
  logic [CMD_W-1:0]       w_fifo_rdata;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic                   w_unused;

  // r_ready_en keeps cmd_ready low while reset is held
  assign cmd_ready = r_ready_en & ~w_fifo_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_unused  = set_busy ^ (^w_fifo_count);

  set_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({cmd_central, cmd_radius, cmd_mode, cmd_tag}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !r_res_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // a real completion beats a coincident timeout
        if (set_valid) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wd == c_wd_last) begin
          w_done_to   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_wd            <= '0;
      r_ready_en      <= 1'b0;
      r_set_en        <= 1'b0;
      r_set_central   <= '0;
      r_set_radius    <= '0;
      r_set_mode      <= '0;
      r_job_tag       <= '0;
      r_res_valid     <= 1'b0;
      r_res_candidate <= '0;
      r_res_tag       <= '0;
      r_res_err       <= 1'b0;
      r_jobs_done     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready_en <= 1'b1;
      r_set_en   <= w_pop;
      if (r_state == ST_ISSUE)     r_wd <= '0;
      else if (r_state == ST_WAIT) r_wd <= r_wd + c_wd_w'(1);
      if (w_pop) {r_set_central, r_set_radius, r_set_mode, r_job_tag} <= w_fifo_rdata;
      if (w_done_ok || w_done_to) begin
        r_res_valid     <= 1'b1;
        r_res_candidate <= w_done_ok ? set_candidate : TIMEOUT_CAND;
        r_res_tag       <= r_job_tag;
        r_res_err       <= w_done_to;
        r_jobs_done     <= r_jobs_done + 16'd1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign set_en        = r_set_en;
  assign set_central   = r_set_central;
  assign set_radius    = r_set_radius;
  assign set_mode      = r_set_mode;
  assign res_valid     = r_res_valid;
  assign res_candidate = r_res_candidate;
  assign res_tag       = r_res_tag;
  assign res_err       = r_res_err;
  assign jobs_done     = r_jobs_done;

endmodule
`default_nettype wire

// File: doc/set_job_scheduler.md
Name: set_job_scheduler

Overview:
- Command front-end that sits directly upstream of the SET candidate-count engine.
- Accepts set-query commands (central, radius, mode, tag) over a valid/ready stream and buffers them in a small FIFO.
- Issues one job at a time to SET via a one-cycle en pulse, waits for SET's one-cycle valid pulse, and captures candidate.
- Presents {candidate, tag, err} on a valid/ready result stream; a watchdog converts a hung SET job into an error result.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, >= 2.
- TAG_W, 4: width of the caller tag carried from command to result.
- TIMEOUT, 32: max cycles in WAIT before the job is aborted; must be > 10.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full, with no combinational path from any other input.
- cmd_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each.
- cmd_radius  in  12  {r1,r2,r3}, 4 bits each.
- cmd_mode  in  2  set operation select.
- cmd_tag  in  TAG_W  caller tag.
- set_en  out  1  one-cycle start pulse to SET.
- set_central  out  24  registered; stable whenever set_en=1.
- set_radius  out  12  registered.
- set_mode  out  2  registered.
- set_busy  in  1  SET busy; status only, never gates issue.
- set_valid  in  1  SET one-cycle completion pulse.
- set_candidate  in  8  SET result; sampled when set_valid=1.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_candidate  out  8  captured count, or 8'hFF on timeout.
- res_tag  out  TAG_W  tag of the completed job.
- res_err  out  1  1 = job timed out.
- jobs_done  out  16  completed-result counter, including errors; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: all outputs are 0 (set_en, set_* data, res_*, jobs_done, cmd_ready deasserts during reset). FIFO is empty, FSM is IDLE, watchdog is 0.
- Reset is asynchronous: asserting rst_n mid-job drops set_en immediately and discards the in-flight job and all queued commands.
- FIFO push when cmd_valid & cmd_ready. Pop happens only on an IDLE->ISSUE transition.
- A simultaneous push and pop on a full FIFO is impossible because cmd_ready is low when full. A simultaneous push and pop when not full keeps the count unchanged.
- Pointers are log2(DEPTH) bits plus a wrap bit; full = count==DEPTH, empty = count==0.
- FSM:
  - IDLE: if !empty & !res_valid, pop the head into the set_* registers and go to ISSUE.
  - ISSUE: set_en=1 for exactly this cycle; clear the watchdog; go to WAIT.
  - WAIT: the watchdog increments each cycle.
    - If set_valid: capture set_candidate, res_tag=job tag, res_err=0, res_valid=1, go to IDLE.
    - Else if watchdog==TIMEOUT-1: res_candidate=8'hFF, res_err=1, res_valid=1, go to IDLE.
    - If set_valid and timeout coincide, set_valid wins (err=0).
- A set_valid arriving outside WAIT is ignored.
- res_valid/res_candidate/res_tag/res_err hold until res_ready & res_valid, then res_valid clears next edge.
- No new job issues while res_valid=1 (single result slot; SET's valid pulse can never be lost).
- jobs_done increments on the cycle a result is loaded into the slot.
- Issue latency: the earliest set_en is the 2nd edge after the accepting push edge (push, IDLE pop, ISSUE).
- Back-to-back: after a result drains, the next set_en follows 2 cycles after the res_ready handshake.
- set_* data registers retain their last job after completion; they only change on a pop.

Decomposition:
- Shared package set_pkg:
  - localparams for the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2).
  - CMD_W = 24+12+2+TAG_W.
  - TIMEOUT_CAND = 8'hFF.
- Sub-module: set_cmd_fifo (parameterised DEPTH, width CMD_W, push/pop/full/empty/count), instantiated once for the command queue.
- FSM, watchdog and result slot stay in set_job_scheduler.

Test Plan:
- Bench uses a SET stub that raises set_valid exactly 9 cycles after set_en with set_candidate = {4'h0, tag}+8'd10.
- Single job: push tag=3 -> exactly one set_en pulse with the pushed central/radius/mode. The result then reads res_valid=1, candidate=8'd13, tag=3, err=0, and jobs_done=1.
- Fill and overflow: hold res_ready=0 and push 6 commands -> cmd_ready drops after DEPTH=4 accepted plus one in flight. Then release res_ready -> 5 results return in push order (tags 0..4) and jobs_done=5.
- Timeout: stub never asserts set_valid -> result appears TIMEOUT cycles after set_en with candidate=8'hFF and err=1. The next queued job then issues normally.
- Race: stub asserts set_valid on exactly watchdog==TIMEOUT-1 -> err=0 with the real candidate, and no second result.
- Reset mid-WAIT: drop rst_n while 2 jobs are queued and 1 is in flight -> outputs go 0 asynchronously. A late stub set_valid after release is ignored, and the FIFO is empty.
- Result backpressure: keep res_ready=0 for 20 cycles -> no set_en issues and the result is stable. A spurious set_valid during this window is ignored.
